tsn_tx_queue_mux: RTL and testbench

Frame-aware, gate-controlled strict-priority multiplexer that merges `NUM_QUEUES` 8-bit AXI-Stream TX client channels into the single MAC transmit client interface. It sits between the per-queue TX client FIFOs and the tri-mode MAC `tx_axis_mac_*` port, in the `tx_mac_aclk` domain. It generalises the fixed single legacy TX path to N traffic classes with per-queue time-aware gates. It also enforces a maximum frame length by truncating oversized frames and flagging them as errored.

---
 rtl/tsn_tx_queue_mux.sv | 185 ++++++++++++++++++
 tb/tb_tsn_tx_queue_mux.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tsn_tx_queue_mux.sv
`default_nettype none
// ============================================================================
//  Module   : tsn_tx_queue_mux
//  Purpose  : Gate-controlled strict-priority merge of NUM_QUEUES byte-wide
//             AXI-Stream TX queues into the MAC TX client. Oversized frames
//             are truncated and flagged. Optional statistics are enabled by
//             defining TSN_TX_MUX_STATS_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module tsn_tx_queue_mux #(
  parameter int NUM_QUEUES      = 4,
  parameter int MAX_FRAME_BYTES = 1522,
  parameter int CNT_W           = 32
) (
  input  logic                          tx_mac_aclk,
  input  logic                          tx_mac_resetn,
  input  logic [8*NUM_QUEUES-1:0]       s_axis_tdata,
  input  logic [NUM_QUEUES-1:0]         s_axis_tvalid,
  input  logic [NUM_QUEUES-1:0]         s_axis_tlast,
  output logic [NUM_QUEUES-1:0]         s_axis_tready,
  input  logic [NUM_QUEUES-1:0]         gate_open,
  output logic [7:0]                    m_axis_tdata,
  output logic                          m_axis_tvalid,
  output logic                          m_axis_tlast,
  output logic                          m_axis_tuser,
  input  logic                          m_axis_tready,
  output logic [$clog2(NUM_QUEUES)-1:0] active_queue,
  output logic                          busy,
  output logic [CNT_W*NUM_QUEUES-1:0]   frame_count,
  output logic [CNT_W-1:0]              trunc_count
);

  localparam int QW  = $clog2(NUM_QUEUES);
  localparam int BCW = $clog2(MAX_FRAME_BYTES + 2);

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_XFER  = 2'd1;
  localparam logic [1:0] c_ST_DRAIN = 2'd2;

  logic [1:0]            r_state;
  logic [1:0]            w_state_next;
  logic [QW-1:0]         r_active_queue;
  logic [BCW-1:0]        r_byte_cnt;
  logic [7:0]            r_tdata;
  logic                  r_tvalid;
  logic                  r_tlast;
  logic                  r_tuser;

  logic [NUM_QUEUES-1:0] w_cand;
  logic [QW-1:0]         w_winner;
  logic                  w_any_cand;
  logic                  w_sel_valid;
  logic                  w_sel_last;
  logic [7:0]            w_sel_data;
  logic                  w_out_ready;
  logic                  w_src_ready;
  logic                  w_accept;
  logic                  w_load;
  logic                  w_trunc;
  logic [NUM_QUEUES-1:0] w_ready_vec;

  assign w_cand     = s_axis_tvalid & gate_open;
  assign w_any_cand = |w_cand;

  // Highest index wins: later iterations override earlier ones.
  always_comb begin
    w_winner = '0;
    for (int q = 0; q < NUM_QUEUES; q++) begin
      if (w_cand[q]) w_winner = QW'(q);
    end
  end

  assign w_sel_valid = s_axis_tvalid[r_active_queue];
  assign w_sel_last  = s_axis_tlast[r_active_queue];
  assign w_sel_data  = s_axis_tdata[8*r_active_queue +: 8];
  assign w_out_ready = !r_tvalid || m_axis_tready;
  assign w_accept    = w_src_ready && w_sel_valid;
  assign w_load      = (r_state == c_ST_XFER) && w_accept;
  // Byte MAX+1 without tlast is cut short; a tlast there is still a good frame.
  assign w_trunc     = w_load && !w_sel_last &&
                       (r_byte_cnt == BCW'(MAX_FRAME_BYTES));

  always_ff @(posedge tx_mac_aclk or negedge tx_mac_resetn) begin
    if (!tx_mac_resetn) r_state <= c_ST_IDLE;
    else                r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_ST_IDLE: begin
        if (w_any_cand) w_state_next = c_ST_XFER;
      end
      c_ST_XFER: begin
        if (w_accept && w_sel_last) w_state_next = c_ST_IDLE;
        else if (w_trunc)           w_state_next = c_ST_DRAIN;
      end
      c_ST_DRAIN: begin
        if (w_accept && w_sel_last) w_state_next = c_ST_IDLE;
      end
      default: w_state_next = c_ST_IDLE;
    endcase
  end

  always_comb begin
    w_src_ready = 1'b0;
    case (r_state)
      c_ST_XFER:  w_src_ready = w_out_ready;
      c_ST_DRAIN: w_src_ready = 1'b1;
      default:    w_src_ready = 1'b0;
    endcase
    w_ready_vec = '0;
    w_ready_vec[r_active_queue] = w_src_ready;
  end

  assign s_axis_tready = w_ready_vec;
  assign busy          = (r_state != c_ST_IDLE);

  always_ff @(posedge tx_mac_aclk or negedge tx_mac_resetn) begin
    if (!tx_mac_resetn) begin
      r_active_queue <= '0;
      r_byte_cnt     <= '0;
      r_tdata        <= '0;
      r_tvalid       <= 1'b0;
      r_tlast        <= 1'b0;
      r_tuser        <= 1'b0;
    end else begin
      if ((r_state == c_ST_IDLE) && w_any_cand) begin
        r_active_queue <= w_winner;
        r_byte_cnt     <= '0;
      end else if (w_load) begin
        r_byte_cnt <= r_byte_cnt + BCW'(1);
      end
      if (w_load) begin
        r_tdata  <= w_sel_data;
        r_tlast  <= w_sel_last || w_trunc;
        r_tuser  <= w_trunc;
        r_tvalid <= 1'b1;
      end else if (m_axis_tready) begin
        r_tvalid <= 1'b0;
      end
    end
  end

  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tlast  = r_tlast;
  assign m_axis_tuser  = r_tuser;
  assign active_queue  = r_active_queue;

`ifdef TSN_TX_MUX_STATS_EN
  // The output beat may outlive the grant, so its source queue travels with it.
  logic [QW-1:0]    r_out_queue;
  logic [CNT_W-1:0] r_trunc_count;
  logic             w_tlast_hs;

  assign w_tlast_hs = r_tvalid && m_axis_tready && r_tlast;

  always_ff @(posedge tx_mac_aclk or negedge tx_mac_resetn) begin
    if (!tx_mac_resetn) begin
      r_out_queue   <= '0;
      r_trunc_count <= '0;
    end else begin
      if (w_load)  r_out_queue   <= r_active_queue;
      if (w_trunc) r_trunc_count <= r_trunc_count + CNT_W'(1);
    end
  end

  for (genvar q = 0; q < NUM_QUEUES; q++) begin : g_frame_cnt
    logic [CNT_W-1:0] r_cnt;
    always_ff @(posedge tx_mac_aclk or negedge tx_mac_resetn) begin
      if (!tx_mac_resetn)                           r_cnt <= '0;
      else if (w_tlast_hs && (r_out_queue == QW'(q))) r_cnt <= r_cnt + CNT_W'(1);
    end
    assign frame_count[CNT_W*q +: CNT_W] = r_cnt;
  end

  assign trunc_count = r_trunc_count;
`else
  assign frame_count = '0;
  assign trunc_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tsn_tx_queue_mux.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tsn_tx_queue_mux
//  Purpose  : Self-checking bench for tsn_tx_queue_mux against a frame-level
//             behavioural model with randomized traffic, gates and backpressure.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tsn_tx_queue_mux;

  localparam int NQ   = 4;
  localparam int MAXB = 64;
  localparam int CW   = 32;
  localparam int QW   = 2;

  logic              clk;
  logic              rst_n;
  logic [8*NQ-1:0]   s_axis_tdata;
  logic [NQ-1:0]     s_axis_tvalid;
  logic [NQ-1:0]     s_axis_tlast;
  logic [NQ-1:0]     s_axis_tready;
  logic [NQ-1:0]     gate_open;
  logic [7:0]        m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tlast;
  logic              m_axis_tuser;
  logic              m_axis_tready;
  logic [QW-1:0]     active_queue;
  logic              busy;
  logic [CW*NQ-1:0]  frame_count;
  logic [CW-1:0]     trunc_count;

  tsn_tx_queue_mux #(
    .NUM_QUEUES(NQ), .MAX_FRAME_BYTES(MAXB), .CNT_W(CW)
  ) dut (
    .tx_mac_aclk(clk), .tx_mac_resetn(rst_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .gate_open(gate_open),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .m_axis_tready(m_axis_tready),
    .active_queue(active_queue), .busy(busy),
    .frame_count(frame_count), .trunc_count(trunc_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Source FIFOs, expected output beats ({tuser,tlast,data}) and frame log.
  logic [7:0] src_d [NQ][$];
  logic       src_l [NQ][$];
  logic [9:0] exp_b [NQ][$];
  logic [NQ-1:0] src_vld;
  int log_src[$];
  int log_len[$];
  int log_user[$];
  int cur_len;

  // Model of what the mux is doing, expressed as frame progress.
  bit   m_busy, m_drop;
  int   m_q, m_bytes;
  bit   e_valid, e_last, e_user;
  logic [7:0] e_data;
  int   e_src, e_active;
  int   e_frames[NQ];
  int   e_trunc;

  int  rdy_pct  = 100;
  int  gap_pct  = 100;
  bit  gate_rand = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_drop = 0; m_q = 0; m_bytes = 0;
    e_valid = 0; e_last = 0; e_user = 0; e_data = '0; e_src = 0; e_active = 0;
    e_trunc = 0; cur_len = 0;
    for (int q = 0; q < NQ; q++) begin
      e_frames[q] = 0;
      src_d[q].delete(); src_l[q].delete(); exp_b[q].delete();
    end
    src_vld = '0; s_axis_tvalid = '0; s_axis_tdata = '0; s_axis_tlast = '0;
  endtask

  task automatic push_frame(input int q, input int len);
    logic [7:0] b;
    int keep;
    bit cut;
    cut  = (len > MAXB + 1);
    keep = cut ? MAXB + 1 : len;
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom);
      src_d[q].push_back(b);
      src_l[q].push_back(i == len - 1);
      if (i < keep) exp_b[q].push_back({cut && (i == keep - 1), i == keep - 1, b});
    end
  endtask

  task automatic tick();
    logic [NQ-1:0] exp_rdy, cand, hs_in;
    logic [9:0] beat;
    bit acc, load;
    @(negedge clk);
    exp_rdy = '0;
    if (m_busy && (m_drop || !e_valid || m_axis_tready)) exp_rdy[m_q] = 1'b1;
    chk("s_axis_tready", 64'(s_axis_tready), 64'(exp_rdy));
    chk("m_axis_tvalid", 64'(m_axis_tvalid), 64'(e_valid));
    if (e_valid) begin
      chk("m_axis_tdata", 64'(m_axis_tdata), 64'(e_data));
      chk("m_axis_tlast", 64'(m_axis_tlast), 64'(e_last));
      chk("m_axis_tuser", 64'(m_axis_tuser), 64'(e_user));
    end
    chk("active_queue", 64'(active_queue), 64'(e_active));
    chk("busy", 64'(busy), 64'(m_busy));
`ifdef TSN_TX_MUX_STATS_EN
    for (int q = 0; q < NQ; q++)
      chk("frame_count", 64'(frame_count[CW*q +: CW]), 64'(e_frames[q]));
    chk("trunc_count", 64'(trunc_count), 64'(e_trunc));
`else
    chk("frame_count_tied", 64'(frame_count), 64'd0);
    chk("trunc_count_tied", 64'(trunc_count), 64'd0);
`endif
    hs_in = s_axis_tvalid & s_axis_tready;
    if (rst_n) begin
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_b[e_src].size() == 0) begin
          chk("sb_extra_beat", 64'(m_axis_tdata), 64'hFFFF);
        end else begin
          beat = exp_b[e_src].pop_front();
          chk("sb_beat", 64'({m_axis_tuser, m_axis_tlast, m_axis_tdata}), 64'(beat));
        end
        cur_len++;
        if (m_axis_tlast) begin
          log_src.push_back(e_src); log_len.push_back(cur_len);
          log_user.push_back(int'(m_axis_tuser)); cur_len = 0;
        end
      end
      acc  = m_busy && s_axis_tvalid[m_q] && exp_rdy[m_q];
      load = 0;
      if (e_valid && m_axis_tready && e_last) e_frames[e_src]++;
      if (!m_busy) begin
        cand = s_axis_tvalid & gate_open;
        if (cand != '0) begin
          for (int q = 0; q < NQ; q++) if (cand[q]) m_q = q;
          m_busy = 1; m_drop = 0; m_bytes = 0; e_active = m_q;
        end
      end else if (acc) begin
        m_bytes++;
        if (m_drop) begin
          if (s_axis_tlast[m_q]) m_busy = 0;
        end else begin
          load = 1; e_data = s_axis_tdata[8*m_q +: 8]; e_src = m_q;
          if (s_axis_tlast[m_q]) begin
            e_last = 1; e_user = 0; m_busy = 0;
          end else if (m_bytes == MAXB + 1) begin
            e_last = 1; e_user = 1; m_drop = 1; e_trunc++;
          end else begin
            e_last = 0; e_user = 0;
          end
        end
      end
      if (load) e_valid = 1;
      else if (m_axis_tready) e_valid = 0;
    end
    @(posedge clk);
    #1;
    if (rst_n) begin
      for (int q = 0; q < NQ; q++) begin
        if (hs_in[q] && src_d[q].size() > 0) begin
          void'(src_d[q].pop_front()); void'(src_l[q].pop_front()); src_vld[q] = 0;
        end
        if (!src_vld[q] && src_d[q].size() > 0 && $urandom_range(99) < gap_pct) src_vld[q] = 1;
        s_axis_tvalid[q]          = src_vld[q];
        s_axis_tdata[8*q +: 8]    = (src_d[q].size() > 0) ? src_d[q][0] : 8'h00;
        s_axis_tlast[q]           = (src_l[q].size() > 0) ? src_l[q][0] : 1'b0;
      end
    end
    m_axis_tready = ($urandom_range(99) < rdy_pct);
    if (gate_rand)
      for (int q = 0; q < NQ; q++) gate_open[q] = ($urandom_range(99) < 80);
  endtask

  function automatic bit pending();
    bit p;
    p = m_busy || e_valid;
    for (int q = 0; q < NQ; q++) if (src_d[q].size() > 0) p = 1;
    return p;
  endfunction

  task automatic run_quiet(input int bound);
    int n;
    n = 0;
    while (pending() && n < bound) begin
      tick();
      n++;
    end
    if (n >= bound) chk("run_quiet_timeout", 64'(n), 64'(bound - 1));
    tick();
    tick();
  endtask

  task automatic chk_out_zero(input string tag);
    chk({tag, "_tvalid"}, 64'(m_axis_tvalid), 64'd0);
    chk({tag, "_tlast"},  64'(m_axis_tlast),  64'd0);
    chk({tag, "_tuser"},  64'(m_axis_tuser),  64'd0);
    chk({tag, "_tdata"},  64'(m_axis_tdata),  64'd0);
    chk({tag, "_tready"}, 64'(s_axis_tready), 64'd0);
    chk({tag, "_busy"},   64'(busy),          64'd0);
    chk({tag, "_active"}, 64'(active_queue),  64'd0);
  endtask

  initial begin
    int n, base;
    rst_n = 0; m_axis_tready = 0; gate_open = '1;
    model_reset();
    #1;
    chk_out_zero("reset");
    repeat (3) tick();
    rst_n = 1;
    tick();

    // Single 64-byte frame on queue 0.
    push_frame(0, 64);
    tick();
    chk("tready_before_grant", 64'(s_axis_tready), 64'h0);
    tick();
    chk("tready_after_grant", 64'(s_axis_tready), 64'h1);
    run_quiet(500);
    chk("single_len",  64'(log_len[$]),  64'd64);
    chk("single_src",  64'(log_src[$]),  64'd0);
    chk("single_user", 64'(log_user[$]), 64'd0);
`ifdef TSN_TX_MUX_STATS_EN
    chk("single_fc0", 64'(frame_count[CW-1:0]), 64'd1);
`endif

    // Priority: queues 1 and 3 become valid together.
    base = log_src.size();
    push_frame(1, 30);
    push_frame(3, 25);
    run_quiet(500);
    chk("prio_first",  64'(log_src[base]),     64'd3);
    chk("prio_second", 64'(log_src[base + 1]), 64'd1);
    chk("prio_active_hold", 64'(active_queue), 64'd1);

    // Gate: queue 3 blocked, gates swap mid-frame without pre-empting queue 2.
    base = log_src.size();
    gate_open = 4'b0111;
    push_frame(3, 20);
    push_frame(2, 40);
    repeat (10) tick();
    gate_open = 4'b1011;
    run_quiet(500);
    chk("gate_first",     64'(log_src[base]),     64'd2);
    chk("gate_first_len", 64'(log_len[base]),     64'd40);
    chk("gate_second",    64'(log_src[base + 1]), 64'd3);
    gate_open = '1;

    // Truncation, recovery, and exact-boundary frame.
    base = log_src.size();
    push_frame(0, 100);
    push_frame(0, 30);
    run_quiet(1000);
    push_frame(0, 65);
    run_quiet(500);
    chk("trunc_len",   64'(log_len[base]),      64'd65);
    chk("trunc_user",  64'(log_user[base]),     64'd1);
    chk("after_len",   64'(log_len[base + 1]),  64'd30);
    chk("after_user",  64'(log_user[base + 1]), 64'd0);
    chk("exact_len",   64'(log_len[base + 2]),  64'd65);
    chk("exact_user",  64'(log_user[base + 2]), 64'd0);
`ifdef TSN_TX_MUX_STATS_EN
    chk("trunc_count_lit", 64'(trunc_count), 64'd1);
`endif

    // Randomized traffic, gates and backpressure.
    rdy_pct = 50; gap_pct = 70; gate_rand = 1;
    for (int r = 0; r < 12; r++) begin
      for (int k = 0; k < 3; k++) push_frame($urandom_range(NQ - 1), $urandom_range(1, 120));
      repeat ($urandom_range(5, 40)) tick();
    end
    run_quiet(20000);
    gate_rand = 0; gate_open = '1;
    n = 0;
    for (int q = 0; q < NQ; q++) n += exp_b[q].size();
    chk("sb_leftover", 64'(n), 64'd0);

    // Reset on byte 30 of a frame, then a clean frame.
    rdy_pct = 100; gap_pct = 100;
    push_frame(1, 60);
    n = 0;
    while (cur_len < 30 && n < 300) begin
      tick();
      n++;
    end
    chk("midreset_reached", 64'(cur_len), 64'd30);
    rst_n = 0;
    #1;
    chk_out_zero("midreset");
    model_reset();
    repeat (2) tick();
    rst_n = 1;
    tick();
    base = log_src.size();
    push_frame(2, 20);
    run_quiet(500);
    chk("post_reset_frames", 64'(log_src.size() - base), 64'd1);
    chk("post_reset_src",    64'(log_src[$]), 64'd2);
    chk("post_reset_len",    64'(log_len[$]), 64'd20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
